// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the RV32I instruction fetch unit.
// FETCH_MISALIGN_CHK_EN widens each fetch buffer entry by a fault bit.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StWait  = 2'd2,
    StDrain = 2'd3
  } fetch_state_e;

  localparam logic [31:0] Nop = 32'h0000_0013;

`ifdef FETCH_MISALIGN_CHK_EN
  localparam int unsigned FaultBits = 1;
`else
  localparam int unsigned FaultBits = 0;
`endif

  // Entry layout, MSB first: {[fault], pc, instr}.
  function automatic int unsigned entry_width(input int unsigned xlen);
    return 2 * xlen + FaultBits;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// Circular FIFO holding fetched {pc, instr} entries; head is read straight from storage.
// Flush empties the buffer on the same edge and overrides any push or pop.
module instr_fetch_unit_fetch_buffer #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 2
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(Depth);

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [Width-1:0] mem_q [Depth];
  logic             push_en, pop_en;

  assign push_en = push && (count_q != Full);
  assign pop_en  = pop && (count_q != '0);

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(push_en) - CntW'(pop_en);
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues single-outstanding word reads at pc_in and buffers {pc, instr} for decode.
// Optional FETCH_MISALIGN_CHK_EN turns misaligned PCs into faulting NOP entries (id_fault).
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned data_Size = 32,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic [data_Size-1:0] pc_in,
  input  logic                 flush,
  output logic                 pc_load,
  output logic                 imem_req,
  output logic [data_Size-1:0] imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [data_Size-1:0] imem_rdata,
  output logic                 id_valid,
  input  logic                 id_ready,
  output logic [data_Size-1:0] id_instr,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic                 id_fault,
`endif
  output logic [data_Size-1:0] id_pc
);

  localparam int unsigned CntW   = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned EntryW = entry_width(data_Size);
  localparam logic [CntW-1:0] Depth = CntW'(BUF_DEPTH);

  fetch_state_e         state_q, state_d;
  logic [data_Size-1:0] cap_addr_q, cap_addr_d;
  logic [data_Size-1:0] fetch_addr;
  logic                 fetch_blocked;
  logic                 push, pop;
  logic [EntryW-1:0]    push_data, head;
  logic [CntW-1:0]      count, count_after_push;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misaligned, fault_set, fault_lock_q;

  assign fetch_addr    = pc_in;
  assign misaligned    = |pc_in[1:0];
  assign fetch_blocked = fault_lock_q;

  // A faulting fetch parks the unit until the next redirect.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      fault_lock_q <= 1'b0;
    end else if (flush) begin
      fault_lock_q <= 1'b0;
    end else if (fault_set) begin
      fault_lock_q <= 1'b1;
    end
  end
`else
  logic unused_pc_lsb;

  assign fetch_addr    = {pc_in[data_Size-1:2], 2'b00};
  assign fetch_blocked = 1'b0;
  assign unused_pc_lsb = ^pc_in[1:0];
`endif

  assign id_valid         = (count != '0);
  assign pop              = id_valid & id_ready;
  assign count_after_push = count + CntW'(1) - CntW'(pop);
  assign imem_addr        = imem_req ? fetch_addr : '0;

  always_comb begin
    state_d    = state_q;
    cap_addr_d = cap_addr_q;
    imem_req   = 1'b0;
    pc_load    = 1'b0;
    push       = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    fault_set  = 1'b0;
    push_data  = {1'b0, cap_addr_q, imem_rdata};
`else
    push_data  = {cap_addr_q, imem_rdata};
`endif

    unique case (state_q)
      StIdle: begin
        if (!flush && !fetch_blocked && (count < Depth)) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (flush) begin
          state_d = StIdle;
`ifdef FETCH_MISALIGN_CHK_EN
        end else if (misaligned) begin
          push      = 1'b1;
          push_data = {1'b1, pc_in, data_Size'(Nop)};
          fault_set = 1'b1;
          state_d   = StIdle;
`endif
        end else begin
          imem_req = 1'b1;
          if (imem_gnt) begin
            pc_load    = 1'b1;
            cap_addr_d = fetch_addr;
            state_d    = StWait;
          end
        end
      end
      StWait: begin
        // Flush beats a coincident response: the data is dropped.
        if (flush) begin
          state_d = imem_rvalid ? StIdle : StDrain;
        end else if (imem_rvalid) begin
          push    = 1'b1;
          state_d = (count_after_push < Depth) ? StReq : StIdle;
        end
      end
      StDrain: begin
        if (imem_rvalid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q    <= StIdle;
      cap_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cap_addr_q <= cap_addr_d;
    end
  end

  instr_fetch_unit_fetch_buffer #(
    .Width (EntryW),
    .Depth (BUF_DEPTH)
  ) u_fetch_buffer (
    .clk    (clk),
    .areset (areset),
    .flush  (flush),
    .push   (push),
    .wdata  (push_data),
    .pop    (pop),
    .rdata  (head),
    .count  (count)
  );

  assign id_instr = head[data_Size-1:0];
  assign id_pc    = head[2*data_Size-1:data_Size];
`ifdef FETCH_MISALIGN_CHK_EN
  assign id_fault = head[EntryW-1];
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_instr_fetch_unit;

  localparam int unsigned Depth = 2;

  logic        clk = 1'b0;
  logic        areset;
  logic [31:0] pc_in;
  logic        flush;
  logic        pc_load;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        id_fault;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .data_Size (32),
    .BUF_DEPTH (Depth)
  ) dut (
    .clk         (clk),
    .areset      (areset),
    .pc_in       (pc_in),
    .flush       (flush),
    .pc_load     (pc_load),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
`ifdef FETCH_MISALIGN_CHK_EN
    .id_fault    (id_fault),
`endif
    .id_pc       (id_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_load;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  vec_t   vecs[17];
  entry_t exp_q[$];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
  task automatic step(input logic [31:0] p, input logic g, input logic rv,
                      input logic [31:0] rd, input logic rdy, input logic fl);
    pc_in = p; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; id_ready = rdy; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] p);
    areset = 1'b0;
    step(p, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) tick();
    areset = 1'b1;
  endtask

  function automatic vec_t mkv(input logic [31:0] pc, input logic gnt, input logic rv,
                               input logic [31:0] rdata, input logic ready, input logic e_req,
                               input logic [31:0] e_addr, input logic e_load,
                               input logic e_valid, input logic [31:0] e_pc,
                               input logic [31:0] e_instr);
    vec_t v;
    v.pc = pc; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.ready = ready;
    v.e_req = e_req; v.e_addr = e_addr; v.e_load = e_load;
    v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  initial begin
    int          pops;
    logic        outst, killed, adv, redirect;
    logic [31:0] out_addr, new_pc;
    int          wait_cnt;

    // Straight-line fetch (rdata = pc ^ A5A5), then back-pressure with a 2-entry buffer.
    vecs[0]  = mkv(32'h00, 0, 0, 32'h0,    1, 0, 32'h00, 0, 0, 32'h0,  32'h0);
    vecs[1]  = mkv(32'h00, 1, 0, 32'h0,    1, 1, 32'h00, 1, 0, 32'h0,  32'h0);
    vecs[2]  = mkv(32'h04, 0, 1, 32'hA5A5, 1, 0, 32'h00, 0, 0, 32'h0,  32'h0);
    vecs[3]  = mkv(32'h04, 1, 0, 32'h0,    1, 1, 32'h04, 1, 1, 32'h00, 32'hA5A5);
    vecs[4]  = mkv(32'h08, 0, 1, 32'hA5A1, 1, 0, 32'h00, 0, 0, 32'h0,  32'h0);
    vecs[5]  = mkv(32'h08, 1, 0, 32'h0,    1, 1, 32'h08, 1, 1, 32'h04, 32'hA5A1);
    vecs[6]  = mkv(32'h0C, 0, 1, 32'hA5AD, 1, 0, 32'h00, 0, 0, 32'h0,  32'h0);
    vecs[7]  = mkv(32'h0C, 0, 0, 32'h0,    1, 1, 32'h0C, 0, 1, 32'h08, 32'hA5AD);
    vecs[8]  = mkv(32'h0C, 1, 0, 32'h0,    0, 1, 32'h0C, 1, 0, 32'h0,  32'h0);
    vecs[9]  = mkv(32'h10, 0, 1, 32'hA5A9, 0, 0, 32'h00, 0, 0, 32'h0,  32'h0);
    vecs[10] = mkv(32'h10, 1, 0, 32'h0,    0, 1, 32'h10, 1, 1, 32'h0C, 32'hA5A9);
    vecs[11] = mkv(32'h14, 0, 1, 32'hA5B5, 0, 0, 32'h00, 0, 1, 32'h0C, 32'hA5A9);
    vecs[12] = mkv(32'h14, 1, 0, 32'h0,    0, 0, 32'h00, 0, 1, 32'h0C, 32'hA5A9);
    vecs[13] = mkv(32'h14, 1, 0, 32'h0,    0, 0, 32'h00, 0, 1, 32'h0C, 32'hA5A9);
    vecs[14] = mkv(32'h14, 0, 0, 32'h0,    1, 0, 32'h00, 0, 1, 32'h0C, 32'hA5A9);
    vecs[15] = mkv(32'h14, 0, 0, 32'h0,    1, 0, 32'h00, 0, 1, 32'h10, 32'hA5B5);
    vecs[16] = mkv(32'h14, 0, 0, 32'h0,    1, 1, 32'h14, 0, 0, 32'h0,  32'h0);

    // Reset held with the memory side toggling: every output stays zero.
    areset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(32'h0000_0120, i[0], ~i[0], 32'hFFFF_FFFF, 1'b1, 1'b0);
      chk1("rst_req", imem_req, 1'b0);
      chk32("rst_addr", imem_addr, 32'h0);
      chk1("rst_pc_load", pc_load, 1'b0);
      chk1("rst_valid", id_valid, 1'b0);
      chk32("rst_instr", id_instr, 32'h0);
      chk32("rst_pc", id_pc, 32'h0);
      tick();
    end

    // Reset mid-transaction, late rvalid arrives in IDLE and must be ignored.
    do_reset(32'h40);
    step(32'h40, 1, 0, 32'h0, 1, 0); tick();
    step(32'h40, 1, 0, 32'h0, 1, 0);
    chk1("mid_gnt_load", pc_load, 1'b1);
    tick();
    areset = 1'b0; #1;
    chk1("mid_rst_req", imem_req, 1'b0);
    tick();
    areset = 1'b1;
    step(32'h40, 0, 1, 32'h1234, 1, 0);
    chk1("late_rv_req", imem_req, 1'b0);
    tick();
    step(32'h40, 0, 0, 32'h0, 1, 0);
    chk1("late_rv_valid", id_valid, 1'b0);
    chk1("release_req", imem_req, 1'b1);
    chk32("release_addr", imem_addr, 32'h40);

    // Vector table.
    do_reset(32'h0);
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].pc, vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].ready, 1'b0);
      chk1($sformatf("vec%0d_req", i), imem_req, vecs[i].e_req);
      chk32($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk1($sformatf("vec%0d_load", i), pc_load, vecs[i].e_load);
      chk1($sformatf("vec%0d_valid", i), id_valid, vecs[i].e_valid);
      if (vecs[i].e_valid) begin
        chk32($sformatf("vec%0d_pc", i), id_pc, vecs[i].e_pc);
        chk32($sformatf("vec%0d_instr", i), id_instr, vecs[i].e_instr);
      end
      tick();
    end

    // Flush in WAIT: late response discarded, next request at the redirected PC.
    do_reset(32'h10);
    step(32'h10, 0, 0, 32'h0, 1, 0); tick();
    step(32'h10, 1, 0, 32'h0, 1, 0);
    chk1("fw_load", pc_load, 1'b1);
    tick();
    step(32'h80, 0, 0, 32'h0, 1, 1);
    chk1("fw_flush_req", imem_req, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      step(32'h80, 1, 0, 32'h0, 1, 0);
      chk1("fw_drain_req", imem_req, 1'b0);
      chk1("fw_drain_load", pc_load, 1'b0);
      tick();
    end
    step(32'h80, 0, 1, 32'hDEAD_BEEF, 1, 0);
    chk1("fw_rv_req", imem_req, 1'b0);
    tick();
    step(32'h80, 0, 0, 32'h0, 1, 0);
    chk1("fw_empty", id_valid, 1'b0);
    tick();
    step(32'h80, 1, 0, 32'h0, 0, 0);
    chk1("fw_new_req", imem_req, 1'b1);
    chk32("fw_new_addr", imem_addr, 32'h80);
    tick();

    // Flush coincident with rvalid and a pop.
    step(32'h84, 0, 1, 32'h1111, 0, 0); tick();
    step(32'h84, 1, 0, 32'h0, 0, 0);
    chk1("fr_valid_before", id_valid, 1'b1);
    chk32("fr_head_pc", id_pc, 32'h80);
    tick();
    step(32'h200, 0, 1, 32'h2222, 1, 1);
    chk1("fr_load", pc_load, 1'b0);
    tick();
    step(32'h200, 0, 0, 32'h0, 1, 0);
    chk1("fr_valid_after", id_valid, 1'b0);
    chk1("fr_idle_req", imem_req, 1'b0);
    tick();

`ifdef FETCH_MISALIGN_CHK_EN
    do_reset(32'h102);
    step(32'h102, 1, 0, 32'h0, 0, 0); tick();
    step(32'h102, 1, 0, 32'h0, 0, 0);
    chk1("mis_req", imem_req, 1'b0);
    chk1("mis_load", pc_load, 1'b0);
    tick();
    step(32'h102, 1, 0, 32'h0, 0, 0);
    chk1("mis_valid", id_valid, 1'b1);
    chk1("mis_fault", id_fault, 1'b1);
    chk32("mis_instr", id_instr, 32'h0000_0013);
    chk32("mis_pc", id_pc, 32'h102);
    tick();
    step(32'h102, 1, 0, 32'h0, 0, 0);
    chk1("mis_hold_req", imem_req, 1'b0);
    tick();
    step(32'h200, 0, 0, 32'h0, 0, 1); tick();
    step(32'h200, 0, 0, 32'h0, 0, 0); tick();
    step(32'h200, 0, 0, 32'h0, 0, 0);
    chk1("mis_resume_req", imem_req, 1'b1);
    chk32("mis_resume_addr", imem_addr, 32'h200);
    tick();
`endif

    // Randomized run against a transaction-level model of the fetch queue.
    do_reset(32'h1000);
    pc_in = 32'h1000;
    pops = 0; outst = 1'b0; killed = 1'b0; adv = 1'b0; redirect = 1'b0;
    out_addr = 32'h0; new_pc = 32'h0; wait_cnt = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (redirect) pc_in = new_pc;
      else if (adv) pc_in = pc_in + 32'd4;
      flush       = ($urandom_range(0, 19) == 0);
      imem_gnt    = ($urandom_range(0, 1) == 1);
      id_ready    = ($urandom_range(0, 9) < 7);
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (outst) begin
        if (wait_cnt == 0) imem_rvalid = 1'b1;
        else wait_cnt--;
      end
      #1;
      chk1("rnd_valid", id_valid, exp_q.size() != 0);
      if (id_valid && id_ready && exp_q.size() != 0) begin
        chk32("rnd_pc", id_pc, exp_q[0].pc);
        chk32("rnd_instr", id_instr, exp_q[0].instr);
        void'(exp_q.pop_front());
        pops++;
      end
      if (imem_req) begin
        chk1("rnd_single_outst", outst, 1'b0);
        chk32("rnd_addr", imem_addr, pc_in);
      end
      chk1("rnd_load", pc_load, imem_req & imem_gnt & ~flush);
      adv      = pc_load;
      redirect = flush;
      new_pc   = {16'h0, $urandom_range(0, 16'h3FFF) << 2};
      if (imem_rvalid) begin
        outst = 1'b0;
        if (!killed && !flush) exp_q.push_back('{pc: out_addr, instr: imem_rdata});
      end
      if (flush) begin
        exp_q.delete();
        if (outst) killed = 1'b1;
      end
      if (imem_req && imem_gnt) begin
        outst    = 1'b1;
        killed   = 1'b0;
        out_addr = pc_in;
        wait_cnt = int'($urandom_range(0, 2));
      end
      chk1("rnd_space", (exp_q.size() + (outst && !killed ? 1 : 0)) <= Depth, 1'b1);
      tick();
    end
    chk1("rnd_progress", pops > 100, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
